// File: rtl/xps2_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: bus address,
// status bit positions, FSM encoding and the frame parity helper.
package xps2_tx_pkg;

    localparam logic [31:0] PS2TX_BASE = 32'h0000_0044;

    localparam int PS2TX_BUSY = 0;
    localparam int PS2TX_DONE = 1;
    localparam int PS2TX_ERR  = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2tx_state_t;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/xps2_sync.sv
// Multi-bit pin synchroniser with a falling-edge strobe per bit; shared by
// the PS/2 transmitter and receiver.
module xps2_sync #(
    parameter int STAGES = 2,
    parameter int W      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_sync,
    output logic [W-1:0] o_fall
);

    logic [STAGES-1:0][W-1:0] r_pipe;
    logic [W-1:0]             r_prev;

    // Reset to the idle-high bus level so no edge is reported on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '1;
            r_prev <= '1;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < STAGES; i++)
                r_pipe[i] <= r_pipe[i-1];
            r_prev <= r_pipe[STAGES-1];
        end
    end

    assign o_sync = r_pipe[STAGES-1];
    assign o_fall = r_prev & ~r_pipe[STAGES-1];

endmodule

// File: rtl/xps2_tx.sv
// PS/2 host-to-device transmitter: a bus write sends one command byte,
// a read returns {err, done, busy}. Pins are open-drain via *_oe.
module xps2_tx
    import xps2_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       we,
    input  logic [7:0] data_in,
    output logic [2:0] data_out,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       tx_active
);

    localparam int CNT_MAX_VAL = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX_VAL + 1);
    localparam logic [CNT_W-1:0] C_INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_SAT  = '1;

    ps2tx_state_t r_state, w_next;

    logic [1:0]       w_sync, w_fall;
    logic             w_clk_s, w_data_s, w_clk_fall, w_unused;
    logic             w_wr, w_inh_done, w_timeout;
    logic [7:0]       r_shift;
    logic             r_par;
    logic [3:0]       r_bit;
    logic [CNT_W-1:0] r_cnt;
    logic             r_data_oe;
    logic             r_busy, r_done, r_err;

    xps2_sync #(.STAGES(SYNC_STAGES), .W(2)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    ({ps2_data_in, ps2_clk_in}),
        .o_sync (w_sync),
        .o_fall (w_fall)
    );

    assign w_clk_s    = w_sync[0];
    assign w_data_s   = w_sync[1];
    assign w_clk_fall = w_fall[0];
    assign w_unused   = w_fall[1];

    assign w_wr       = sel & we;
    assign w_inh_done = (r_state == INHIBIT) && (r_cnt == C_INH_LAST);
    assign w_timeout  = ((r_state == SEND) || (r_state == ACK) || (r_state == WAIT_IDLE))
                        && (r_cnt == C_TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        case (r_state)
            IDLE:      if (w_wr) w_next = INHIBIT;
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (w_inh_done) w_next = START;
            end
            START: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                w_next      = SEND;
            end
            SEND: begin
                ps2_data_oe = r_data_oe;
                if (w_clk_fall && r_bit == 4'd9) w_next = ACK;
            end
            ACK:       if (w_clk_fall) w_next = WAIT_IDLE;
            WAIT_IDLE: if (w_clk_s && w_data_s) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
        if (w_timeout) w_next = IDLE;
    end

    // Shared counter: inhibit length first, then the frame timeout from clock release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                INHIBIT:              r_cnt <= w_inh_done ? '0 : r_cnt + 1'b1;
                SEND, ACK, WAIT_IDLE: if (r_cnt != C_CNT_SAT) r_cnt <= r_cnt + 1'b1;
                default:              r_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_bit     <= '0;
            r_data_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_wr) begin
                    r_shift <= data_in;
                    r_par   <= odd_parity(data_in);
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                START: begin
                    r_bit     <= '0;
                    r_data_oe <= 1'b1;
                end
                SEND: if (w_clk_fall) begin
                    if (r_bit < 4'd8)       r_data_oe <= ~r_shift[r_bit[2:0]];
                    else if (r_bit == 4'd8) r_data_oe <= ~r_par;
                    else                    r_data_oe <= 1'b0;
                    r_bit <= r_bit + 1'b1;
                end
                ACK: if (w_clk_fall) begin
                    r_done <= ~w_data_s;
                    r_err  <= w_data_s;
                end
                WAIT_IDLE: if (w_clk_s && w_data_s) r_busy <= 1'b0;
                default: ;
            endcase
            if (w_timeout) begin
                r_data_oe <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
                r_err     <= 1'b1;
            end
        end
    end

    always_comb begin
        data_out             = '0;
        data_out[PS2TX_BUSY] = r_busy;
        data_out[PS2TX_DONE] = r_done;
        data_out[PS2TX_ERR]  = r_err;
    end

    assign tx_active = (r_state != IDLE);

endmodule

// File: tb/tb_xps2_tx.sv
// Bench for xps2_tx: a device BFM clocks frames out of the transmitter and
// compares received bytes against a scoreboard of written commands.
module tb_xps2_tx;
    import xps2_tx_pkg::*;

    localparam int INH  = 10;
    localparam int TMO  = 4000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst, sel, we;
    logic [7:0] data_in;
    logic [2:0] data_out;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, tx_active;
    logic       dev_clk_low, dev_data_low;

    typedef struct packed { logic [7:0] b; logic par; } exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    xps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .we          (we),
        .data_in     (data_in),
        .data_out    (data_out),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_active   (tx_active)
    );

    task automatic bus_write(input logic [7:0] b);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; data_in = b;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] b);
        exp_t e;
        e.b   = b;
        e.par = ($countones(b) % 2 == 0);
        exp_q.push_back(e);
    endtask

    task automatic wait_inhibit(output int inh, output int st);
        int guard = 0;
        inh = 0; st = 0;
        while (!ps2_clk_oe && guard < 100) begin @(negedge clk); guard++; end
        while (ps2_clk_oe && !ps2_data_oe && guard < 1000) begin inh++; @(negedge clk); guard++; end
        while (ps2_clk_oe && ps2_data_oe && guard < 1000) begin st++; @(negedge clk); guard++; end
    endtask

    // Device side: ten clocks sampling on the rising edge, then the ack clock.
    task automatic dev_clock(input logic ack, output logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            bits[i] = ps2_data_in;
            dev_clk_low = 1'b0;
        end
        repeat (HALF/2) @(negedge clk);
        dev_data_low = ack;
        repeat (HALF/2) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF/2) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_not_busy(input string nm);
        int guard = 0;
        while (data_out[PS2TX_BUSY] && guard < 500) begin @(negedge clk); guard++; end
        checks++;
        if (data_out[PS2TX_BUSY]) begin
            errors++; $display("FAIL %s busy-timeout: busy still %b", nm, data_out[PS2TX_BUSY]);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (data_out !== 3'b000) begin errors++; $display("FAIL reset_status got %b want 000", data_out); end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL reset_oe got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        checks++;
        if (tx_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", tx_active); end
    endtask

    task automatic test_frame(input logic [7:0] b, input logic ack, input logic mid_write,
                              input logic [2:0] exp_status, input string nm);
        int         inh, st;
        logic [9:0] bits;
        exp_t       e;
        push_exp(b);
        bus_write(b);
        wait_inhibit(inh, st);
        checks++;
        if (inh != INH) begin errors++; $display("FAIL %s inhibit_len got %0d want %0d", nm, inh, INH); end
        checks++;
        if (st != 1) begin errors++; $display("FAIL %s start_len got %0d want 1", nm, st); end
        fork
            dev_clock(ack, bits);
            if (mid_write) begin
                repeat (4*HALF) @(negedge clk);
                bus_write(8'h55);
                @(negedge clk);
                checks++;
                if (data_out !== 3'b001) begin errors++; $display("FAIL %s busy_write_status got %b want 001", nm, data_out); end
            end
        join
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            if (bits[7:0] !== e.b) begin errors++; $display("FAIL %s data got %h want %h", nm, bits[7:0], e.b); end
            checks++;
            if (bits[8] !== e.par) begin errors++; $display("FAIL %s parity got %b want %b", nm, bits[8], e.par); end
            checks++;
            if (bits[9] !== 1'b1) begin errors++; $display("FAIL %s stop got %b want 1", nm, bits[9]); end
        end
        wait_not_busy(nm);
        repeat (2) @(negedge clk);
        checks++;
        if (data_out !== exp_status) begin errors++; $display("FAIL %s status got %b want %b", nm, data_out, exp_status); end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL %s end_oe got %b want 00", nm, {ps2_clk_oe, ps2_data_oe}); end
        checks++;
        if (tx_active !== 1'b0) begin errors++; $display("FAIL %s end_active got %b want 0", nm, tx_active); end
    endtask

    task automatic test_timeout();
        int inh, st, n;
        bus_write(8'h3C);
        wait_inhibit(inh, st);
        n = 0;
        while (!data_out[PS2TX_ERR] && n < TMO + 500) begin @(negedge clk); n++; end
        checks++;
        if (n != TMO) begin errors++; $display("FAIL timeout cycles got %0d want %0d", n, TMO); end
        checks++;
        if (data_out !== 3'b100) begin errors++; $display("FAIL timeout status got %b want 100", data_out); end
        checks++;
        if ({ps2_clk_oe, ps2_data_oe, tx_active} !== 3'b000) begin
            errors++; $display("FAIL timeout lines got %b want 000", {ps2_clk_oe, ps2_data_oe, tx_active});
        end
    endtask

    task automatic test_reset_midsend();
        int inh, st;
        bus_write(8'hAA);
        wait_inhibit(inh, st);
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL midsend data_oe got %b want 1", ps2_data_oe); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin errors++; $display("FAIL midsend_rst oe got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
        checks++;
        if (data_out !== 3'b000) begin errors++; $display("FAIL midsend_rst status got %b want 000", data_out); end
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        test_frame(8'hFF, 1'b1, 1'b0, 3'b010, "after_rst_ff");
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; we = 1'b0; data_in = '0;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_frame(8'hED, 1'b1, 1'b0, 3'b010, "ed");
        test_frame(8'h01, 1'b1, 1'b0, 3'b010, "p01");
        test_frame(8'h00, 1'b1, 1'b0, 3'b010, "p00");
        test_frame(8'hFF, 1'b1, 1'b0, 3'b010, "pff");
        test_frame(8'hA5, 1'b0, 1'b0, 3'b100, "noack");
        test_timeout();
        test_frame(8'hF4, 1'b1, 1'b1, 3'b010, "back_to_back");
        test_reset_midsend();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard leftover %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
